// File: rtl/rqst_frame_decoder.sv
// Assembles an address byte plus NB little-endian data bytes into one si_addr/si_data word.
// An inter-byte timeout drops a partial frame so the decoder resynchronises on the next address.
`ifndef __REG_ADDR_WIDTH
`define __REG_ADDR_WIDTH 8
`endif
`ifndef __REG_DATA_WIDTH
`define __REG_DATA_WIDTH 32
`endif

module rqst_frame_decoder #(
    parameter int unsigned ADDR_WIDTH     = `__REG_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH     = `__REG_DATA_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_rdy,
    output logic [ADDR_WIDTH-1:0] si_addr,
    output logic [DATA_WIDTH-1:0] si_data,
    output logic                  si_rdy,
    output logic                  frame_err
);

    localparam int unsigned NB = (DATA_WIDTH + 7) / 8;
    localparam int unsigned IW = $clog2(NB + 1);
    localparam int unsigned CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [IW-1:0] LastIdx = IW'(NB - 1);
    localparam logic [CW-1:0] CntMax  = '1;
    // Count value on the edge before the counter would reach TIMEOUT_CYCLES.
    localparam logic [CW-1:0] CntLast = CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    typedef enum logic {StAddr, StData} state_t;

    state_t                  state_q;
    logic [IW-1:0]           idx_q;
    logic [CW-1:0]           cnt_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [8*NB-1:0]         buf_q;
    logic [8*NB-1:0]         buf_d;

    // Buffer with the incoming byte merged in, so the last byte can go straight to si_data.
    always_comb begin
        buf_d = buf_q;
        for (int k = 0; k < NB; k++) begin
            if (idx_q == IW'(k)) begin
                buf_d[8*k +: 8] = rx_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StAddr;
            idx_q     <= '0;
            cnt_q     <= '0;
            addr_q    <= '0;
            buf_q     <= '0;
            si_addr   <= '0;
            si_data   <= '0;
            si_rdy    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            si_rdy    <= 1'b0;
            frame_err <= 1'b0;
            unique case (state_q)
                StAddr: begin
                    if (rx_rdy) begin
                        addr_q  <= rx_data[ADDR_WIDTH-1:0];
                        buf_q   <= '0;
                        idx_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= StData;
                    end
                end
                StData: begin
                    if (rx_rdy) begin
                        buf_q <= buf_d;
                        idx_q <= idx_q + IW'(1);
                        cnt_q <= '0;
                        if (idx_q == LastIdx) begin
                            state_q <= StAddr;
                            si_addr <= addr_q;
                            si_data <= buf_d[DATA_WIDTH-1:0];
                            si_rdy  <= 1'b1;
                        end
                    end else if (TIMEOUT_CYCLES != 0 && cnt_q == CntLast) begin
                        cnt_q     <= cnt_q + CW'(1);
                        state_q   <= StAddr;
                        frame_err <= 1'b1;
                    end else if (cnt_q != CntMax) begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= StAddr;
            endcase
        end
    end

endmodule

// File: tb/tb_rqst_frame_decoder.sv
// Directed bench for rqst_frame_decoder: a wide instance (8/16) and a narrow one (4/12).
// Completed frames are checked against a queue of expected (addr, data) pairs.
module tb_rqst_frame_decoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        rx_rdy;
    logic [7:0]  rx_data;
    logic [7:0]  si_addr;
    logic [15:0] si_data;
    logic        si_rdy;
    logic        frame_err;
    logic [3:0]  n_addr;
    logic [11:0] n_data;
    logic        n_rdy;
    logic        n_err;

    rqst_frame_decoder #(
        .ADDR_WIDTH    (8),
        .DATA_WIDTH    (16),
        .TIMEOUT_CYCLES(10)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_rdy   (rx_rdy),
        .si_addr  (si_addr),
        .si_data  (si_data),
        .si_rdy   (si_rdy),
        .frame_err(frame_err)
    );

    rqst_frame_decoder #(
        .ADDR_WIDTH    (4),
        .DATA_WIDTH    (12),
        .TIMEOUT_CYCLES(10)
    ) dut_n (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_rdy   (rx_rdy),
        .si_addr  (n_addr),
        .si_data  (n_data),
        .si_rdy   (n_rdy),
        .frame_err(n_err)
    );

    typedef struct packed {
        logic [7:0]  addr;
        logic [15:0] data;
    } frame_t;

    frame_t exp_q[$];
    int     n_checks = 0;
    int     n_pass   = 0;
    int     exp_err  = 0;
    int     err_seen = 0;

    logic [7:0] b2b_bytes [6] = '{8'h01, 8'hAA, 8'h55, 8'h02, 8'h0F, 8'hF0};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_data = b;
        rx_rdy  = 1'b1;
        tick();
        rx_rdy  = 1'b0;
    endtask

    task automatic idle(input int n);
        rx_rdy = 1'b0;
        repeat (n) tick();
    endtask

    // Scoreboard side: every si_rdy pulse must match the oldest expected frame.
    always @(negedge clk) begin
        frame_t f;
        if (si_rdy) begin
            check("si_rdy_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                f = exp_q.pop_front();
                check("frame_addr", 32'(si_addr), 32'(f.addr));
                check("frame_data", 32'(si_data), 32'(f.data));
            end
        end
        if (frame_err) err_seen++;
        if (si_rdy || frame_err) check("rdy_err_exclusive", 32'(si_rdy & frame_err), 32'd0);
    end

    initial begin
        rst     = 1'b1;
        rx_rdy  = 1'b0;
        rx_data = 8'h00;
        repeat (2) tick();
        check("reset_si_addr", 32'(si_addr), 32'h0);
        check("reset_si_data", 32'(si_data), 32'h0);
        check("reset_si_rdy", 32'(si_rdy), 32'h0);
        check("reset_frame_err", 32'(frame_err), 32'h0);
        rst = 1'b0;
        idle(2);

        // Single spaced frame.
        send(8'h03);
        idle(2);
        send(8'h34);
        idle(2);
        exp_q.push_back(frame_t'{addr: 8'h03, data: 16'h1234});
        send(8'h12);
        check("t1_si_rdy", 32'(si_rdy), 32'h1);
        check("t1_si_addr", 32'(si_addr), 32'h03);
        check("t1_si_data", 32'(si_data), 32'h1234);
        tick();
        check("t1_si_rdy_drop", 32'(si_rdy), 32'h0);
        check("t1_addr_hold", 32'(si_addr), 32'h03);
        check("t1_data_hold", 32'(si_data), 32'h1234);
        idle(2);

        // Back-to-back frames with rx_rdy held high.
        for (int i = 0; i < 6; i++) begin
            rx_data = b2b_bytes[i];
            rx_rdy  = 1'b1;
            if (i == 2) exp_q.push_back(frame_t'{addr: 8'h01, data: 16'h55AA});
            if (i == 5) exp_q.push_back(frame_t'{addr: 8'h02, data: 16'hF00F});
            tick();
            check("t2_rdy_pulse", 32'(si_rdy), 32'(i == 2 || i == 5));
        end
        rx_rdy = 1'b0;
        idle(2);

        // Timeout drops the partial frame.
        send(8'h05);
        send(8'hAA);
        idle(9);
        check("t3_no_err_early", 32'(frame_err), 32'h0);
        idle(1);
        exp_err++;
        check("t3_frame_err", 32'(frame_err), 32'h1);
        check("t3_no_si_rdy", 32'(si_rdy), 32'h0);
        check("t3_addr_hold", 32'(si_addr), 32'h02);
        check("t3_data_hold", 32'(si_data), 32'hF00F);
        idle(1);
        check("t3_err_drop", 32'(frame_err), 32'h0);
        send(8'h01);
        send(8'h02);
        exp_q.push_back(frame_t'{addr: 8'h01, data: 16'h0002});
        send(8'h00);
        check("t3_resync_rdy", 32'(si_rdy), 32'h1);
        idle(2);

        // Byte on the edge where the timeout would fire is accepted.
        send(8'h05);
        idle(9);
        send(8'h66);
        check("t4_no_err", 32'(frame_err), 32'h0);
        exp_q.push_back(frame_t'{addr: 8'h05, data: 16'h7766});
        send(8'h77);
        check("t4_si_rdy", 32'(si_rdy), 32'h1);
        idle(12);

        // Reset mid-frame.
        send(8'h07);
        send(8'h11);
        rst = 1'b1;
        tick();
        check("t5_rst_si_addr", 32'(si_addr), 32'h0);
        check("t5_rst_si_data", 32'(si_data), 32'h0);
        check("t5_rst_si_rdy", 32'(si_rdy), 32'h0);
        check("t5_rst_frame_err", 32'(frame_err), 32'h0);
        check("t5_rst_n_data", 32'(n_data), 32'h0);
        rst = 1'b0;
        send(8'h09);
        send(8'h22);
        exp_q.push_back(frame_t'{addr: 8'h09, data: 16'h3322});
        send(8'h33);
        check("t5_si_rdy", 32'(si_rdy), 32'h1);
        idle(2);

        // Narrow instance truncates address and data.
        exp_q.push_back(frame_t'{addr: 8'hF7, data: 16'hFFFF});
        send(8'hF7);
        send(8'hFF);
        send(8'hFF);
        check("t6_n_rdy", 32'(n_rdy), 32'h1);
        check("t6_n_addr", 32'(n_addr), 32'h7);
        check("t6_n_data", 32'(n_data), 32'hFFF);
        check("t6_n_err", 32'(n_err), 32'h0);
        idle(3);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("frame_err_count", 32'(err_seen), 32'(exp_err));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rqst_frame_decoder.md
# rqst_frame_decoder

Byte-stream to simple-interface frame decoder. It sits between the PC link receiver and the bank of request registers. It assembles one address byte plus N little-endian data bytes into a single `si_addr`/`si_data` word and fires a one-cycle `si_rdy` strobe toward the registers. An inter-byte timeout resynchronises the decoder after a lost byte.

## Interface

Parameters:

- `ADDR_WIDTH`, default `` `__REG_ADDR_WIDTH ``: register address width, legal range 1..8.
- `DATA_WIDTH`, default `` `__REG_DATA_WIDTH ``: register data width, legal range 1..32. NB = ceil(DATA_WIDTH/8) data bytes per frame.
- `TIMEOUT_CYCLES`, default 1000: idle cycles allowed between bytes inside a frame. 0 disables the timeout.

Ports:

- `clk`  in  1: single clock. All logic is on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `rx_data`  in  8: received byte.
- `rx_rdy`  in  1: `rx_data` valid this cycle. Every high cycle is one byte; there is no backpressure.
- `si_addr`  out  ADDR_WIDTH: address of the last completed frame.
- `si_data`  out  DATA_WIDTH: data of the last completed frame.
- `si_rdy`  out  1: one-cycle strobe, asserted when a frame completes.
- `frame_err`  out  1: one-cycle strobe, asserted when a partial frame is dropped on timeout.

## Operation

- Frame format: byte 0 is the address; `rx_data[ADDR_WIDTH-1:0]` is used and the upper bits are ignored. Bytes 1..NB are data, least significant byte first; byte k maps to data bits [8k-1:8k-8].
- In the last data byte, bits above DATA_WIDTH are discarded.
- States:
  - ADDR (reset state):
    - `rx_rdy`=1: latch the address into the frame buffer, clear the byte index and the timeout counter, go to DATA.
  - DATA:
    - `rx_rdy`=1: store the byte at the current index, increment the index, clear the timeout counter.
    - If the stored byte was byte NB: go to ADDR.
    - `rx_rdy`=0: increment the timeout counter.
    - Counter reaches TIMEOUT_CYCLES: go to ADDR, discard the buffer.
- Output register updates:
  - Frame complete: `si_addr`/`si_data` load from the buffer and `si_rdy`=1 for exactly one cycle.
  - Otherwise `si_addr`/`si_data` hold and `si_rdy`=0.
- Timeout: `frame_err`=1 for exactly one cycle. `si_addr`/`si_data` are unchanged and `si_rdy` stays 0.
- A byte arriving on the same edge at which the counter would reach TIMEOUT_CYCLES is accepted; the timeout does not fire.
- There is no timeout in ADDR; the decoder waits indefinitely for an address byte.
- Timeout counter width is `$clog2(TIMEOUT_CYCLES+1)` and the counter saturates; it never wraps.
- The byte index is sized to count 0..NB and does not wrap within a frame.
- Reset values: state=ADDR, index=0, counter=0, `si_addr`=0, `si_data`=0, `si_rdy`=0, `frame_err`=0.
- Reset mid-frame discards all partial data. The next `rx_rdy` byte after reset is treated as an address.

## Timing

- Latency: the last data byte is sampled on edge E; `si_rdy`, `si_addr` and `si_data` are valid in the cycle after edge E (registered outputs, one cycle).
- Throughput: `rx_rdy` may stay high continuously. Frames complete every NB+1 cycles, and the next address byte is accepted in the cycle right after the last data byte.
- `si_rdy` never stays high two consecutive cycles, except for back-to-back frames when NB+1=1, which is impossible because NB ≥ 1.
- Timeout: the last byte is sampled on edge E0. With no further `rx_rdy`, the counter reaches TIMEOUT_CYCLES on edge E0+TIMEOUT_CYCLES, and `frame_err` is high during the following cycle.
- `si_rdy` and `frame_err` are never high in the same cycle.

## Test plan

Bench parameters: ADDR_WIDTH=8, DATA_WIDTH=16, TIMEOUT_CYCLES=10, unless a scenario says otherwise.

1. Single frame: bytes 0x03, 0x34, 0x12 on three spaced `rx_rdy` pulses -> one `si_rdy` pulse one cycle after the 0x12 edge, with `si_addr`=0x03 and `si_data`=0x1234. Both outputs hold afterwards.
2. Back-to-back frames: `rx_rdy` held high for 6 cycles carrying 0x01, 0xAA, 0x55, 0x02, 0x0F, 0xF0 -> two `si_rdy` pulses 3 cycles apart, giving (0x01, 0x55AA) then (0x02, 0xF00F).
3. Timeout: 0x05, 0xAA, then 10 idle cycles -> `frame_err` pulses once, there is no `si_rdy`, and outputs keep their previous values. A following frame 0x01, 0x02, 0x00 decodes to (0x01, 0x0002).
4. Timeout boundary: 0x05, then 9 idle cycles, then a byte on the 10th cycle -> no `frame_err`; the frame continues and completes normally.
5. Reset mid-frame: 0x07, 0x11, then `rst` for 1 cycle -> all outputs are 0. Next, 0x09, 0x22, 0x33 -> (0x09, 0x3322), with no stale data.
6. Narrow data, with DATA_WIDTH=12 and ADDR_WIDTH=4: bytes 0xF7, 0xFF, 0xFF -> `si_addr`=0x7 and `si_data`=0xFFF.
